s2p_param: RTL and testbench
============================

S2P_PARAM -- requirements
Module: s2p_param

Interface
REQ-001 Parameter DW, default 6, output word width in bits; legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 0; 0 = first accepted bit lands in data_b[0], 1 = first accepted bit lands in data_b[DW-1].
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 valid_a  input  1  serial bit valid.
REQ-006 data_a  input  1  serial data bit.
REQ-007 ready_a  output  1  block accepts data_a this cycle; a bit transfers when valid_a && ready_a.
REQ-008 valid_b  output  1  data_b holds a word; stays high until taken.
REQ-009 ready_b  input  1  consumer takes data_b when valid_b && ready_b.
REQ-010 data_b  output  DW  parallel word, registered.
REQ-011 flush  input  1  present only with S2P_FLUSH_EN; request to emit the partial word.
REQ-012 cnt_b  output  $clog2(DW+1)  present only with S2P_FLUSH_EN; number of valid bits in data_b.

Function
REQ-013 Bit counter cnt (0..DW-1) and accumulator acc[DW-1:0] advance only on a transfer; cnt wraps DW-1 -> 0 on the DW-th transfer.
REQ-014 MSB_FIRST=0: acc <= {data_a, acc[DW-1:1]}; MSB_FIRST=1: acc <= {acc[DW-2:0], data_a}.
REQ-015 On the DW-th transfer, the completed word (including the current data_a) loads data_b, and valid_b is 1 in the next cycle (latency 1 clock after the last bit).
REQ-016 valid_b clears on valid_b && ready_b unless a new word loads in the same cycle, in which case valid_b stays 1 and data_b takes the new word.
REQ-017 Accumulation continues while valid_b is held; ready_a = !(cnt==DW-1 && valid_b && !ready_b), with no other stall (no flush pending) -- combinational path ready_b -> ready_a permitted.
REQ-018 data_b and valid_b hold their values unchanged while valid_b && !ready_b (no overwrite, no loss).
REQ-019 Back-to-back words with ready_b held 1 sustain one bit per cycle, valid_b pulsing one cycle per DW bits.

Reset
REQ-020 While rst=1: cnt=0, acc=0, data_b=0, valid_b=0, ready_a=0, pending flush=0, cnt_b=0.
REQ-021 rst asserted mid-word discards the partial word; first transfer after release is bit 0 of a new word.
REQ-022 ready_a rises combinationally once rst deasserts (first edge after release may transfer).

Configuration
REQ-023 Macro S2P_FLUSH_EN defined: flush and cnt_b ports exist; without it neither port exists and only full DW-bit words are emitted.
REQ-024 flush=1 with k>0 accumulated bits (counting a same-cycle transfer) loads a partial word: MSB_FIRST=0 bits in data_b[k-1:0], upper bits 0; MSB_FIRST=1 bits in data_b[DW-1:DW-k], lower bits 0; cnt_b=k; cnt and acc clear.
REQ-025 Full words always report cnt_b=DW; flush with k=0 and no transfer is ignored.
REQ-026 flush when the output slot is occupied and not draining sets pending; pending forces ready_a=0 and executes on the first cycle the slot frees, then clears.
REQ-027 flush coinciding with the DW-th transfer emits a single full word, cnt_b=DW.

Verification
REQ-028 DW=6, MSB_FIRST=0, ready_b=1, bits 1,0,1,1,0,0 on consecutive cycles -> data_b=6'b001101, valid_b=1 for exactly one cycle, one clock after the sixth bit.
REQ-029 Same stream with MSB_FIRST=1 -> data_b=6'b101100.
REQ-030 ready_b=0, 12 continuous bits -> first word held stable, ready_a drops with cnt=5; raising ready_b for one cycle transfers word 1, ready_a returns high, sixth bit of word 2 accepted that cycle.
REQ-031 rst pulse after 3 bits, then 6 bits 111111 -> data_b=6'b111111, no trace of pre-reset bits.
REQ-032 S2P_FLUSH_EN, DW=6, MSB_FIRST=0: bits 1,1,0 then flush -> data_b=6'b000011, cnt_b=3, next 6 bits form a clean full word with cnt_b=6.
REQ-033 S2P_FLUSH_EN: flush while valid_b=1, ready_b=0 -> ready_a=0 until ready_b=1, then partial word emitted next cycle with correct cnt_b.

Source files
------------

// File: rtl/s2p_param.sv
// Serial-to-parallel converter with a one-word registered output slot.
// Optional partial-word flush and bit count output under S2P_FLUSH_EN.
module s2p_param #(
    parameter int DW        = 6,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          valid_a,
    input  logic          data_a,
    output logic          ready_a,
    output logic          valid_b,
    input  logic          ready_b,
    output logic [DW-1:0] data_b
`ifdef S2P_FLUSH_EN
    ,
    input  logic                   flush,
    output logic [$clog2(DW+1)-1:0] cnt_b
`endif
);
    localparam int CW = $clog2(DW+1);

    logic [CW-1:0] cnt;
    logic [DW-1:0] acc;
    logic [DW-1:0] acc_nx;
    logic          xfer;
    logic          last;
    logic          free;
    logic          stall;

    always_comb begin
        if (MSB_FIRST) acc_nx = {acc[DW-2:0], data_a};
        else           acc_nx = {data_a, acc[DW-1:1]};
    end

    // Output slot can take a new word when empty or draining this cycle.
    assign free    = !valid_b || ready_b;
    assign ready_a = !rst && !stall &&
                     !(cnt == CW'(DW-1) && valid_b && !ready_b);
    assign xfer    = valid_a && ready_a;
    assign last    = xfer && (cnt == CW'(DW-1));

`ifdef S2P_FLUSH_EN
    logic          pend;
    logic          fl_go;
    logic [CW-1:0] k;
    logic [DW-1:0] word;
    logic [DW-1:0] part;

    assign stall = pend;
    assign k     = cnt + CW'(xfer);
    assign fl_go = (flush || pend) && !last && (k != '0);

    // Align the k collected bits to the low end (LSB-first) or high end.
    always_comb begin
        word = xfer ? acc_nx : acc;
        if (MSB_FIRST) part = word << (CW'(DW) - k);
        else           part = word >> (CW'(DW) - k);
    end
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            acc     <= '0;
            data_b  <= '0;
            valid_b <= 1'b0;
`ifdef S2P_FLUSH_EN
            pend    <= 1'b0;
            cnt_b   <= '0;
`endif
        end
`ifdef S2P_FLUSH_EN
        else if (fl_go && free) begin
            cnt     <= '0;
            acc     <= '0;
            data_b  <= part;
            cnt_b   <= k;
            valid_b <= 1'b1;
            pend    <= 1'b0;
        end
`endif
        else begin
            if (xfer) begin
                acc <= acc_nx;
                cnt <= last ? '0 : cnt + CW'(1);
            end
            if (last) begin
                data_b  <= acc_nx;
                valid_b <= 1'b1;
`ifdef S2P_FLUSH_EN
                cnt_b   <= CW'(DW);
`endif
            end else if (ready_b) begin
                valid_b <= 1'b0;
            end
`ifdef S2P_FLUSH_EN
            if (fl_go) pend <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_s2p_param.sv
// Randomized scoreboard bench for s2p_param (LSB-first and MSB-first
// instances side by side); flush scenarios run when S2P_FLUSH_EN is set.
module tb_s2p_param;
    localparam int DW = 6;
    localparam int CW = $clog2(DW+1);
`ifdef S2P_FLUSH_EN
    localparam bit FL = 1'b1;
`else
    localparam bit FL = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_a = 1'b0;
    logic          data_a = 1'b0;
    logic          ready_b = 1'b0;
    logic          flush = 1'b0;
    logic          ready_a, ready_a1;
    logic          valid_b0, valid_b1;
    logic [DW-1:0] data0, data1;
    logic [CW-1:0] cnt0, cnt1;

    int total = 0;
    int bad = 0;

    bit            cur[$];
    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    int            qc[$];
    bit            slot = 0;
    bit            pend = 0;

    always #5 clk = ~clk;

    s2p_param #(.DW(DW), .MSB_FIRST(1'b0)) u0 (
        .clk(clk), .rst(rst), .valid_a(valid_a), .data_a(data_a),
        .ready_a(ready_a), .valid_b(valid_b0), .ready_b(ready_b),
        .data_b(data0)
`ifdef S2P_FLUSH_EN
        , .flush(flush), .cnt_b(cnt0)
`endif
    );

    s2p_param #(.DW(DW), .MSB_FIRST(1'b1)) u1 (
        .clk(clk), .rst(rst), .valid_a(valid_a), .data_a(data_a),
        .ready_a(ready_a1), .valid_b(valid_b1), .ready_b(ready_b),
        .data_b(data1)
`ifdef S2P_FLUSH_EN
        , .flush(flush), .cnt_b(cnt1)
`endif
    );

`ifndef S2P_FLUSH_EN
    assign cnt0 = CW'(DW);
    assign cnt1 = CW'(DW);
`endif

    task automatic chk(input bit ok, input string name,
                       input longint act, input longint exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Place the collected bits per the bit-order rule; unused bits stay 0.
    function automatic logic [DW-1:0] build(input bit b[$], input bit msb);
        logic [DW-1:0] w = '0;
        for (int i = 0; i < b.size(); i++) begin
            if (msb) w[DW-1-i] = b[i];
            else     w[i] = b[i];
        end
        return w;
    endfunction

    task automatic emit();
        q0.push_back(build(cur, 1'b0));
        q1.push_back(build(cur, 1'b1));
        qc.push_back(cur.size());
        cur.delete();
        slot = 1;
    endtask

    task automatic cycle(input bit va, input bit da, input bit rb, input bit fl);
        bit exp_ra, xf, fr;
        @(negedge clk);
        #1;
        valid_a = va; data_a = da; ready_b = rb; flush = fl;
        #1;
        exp_ra = !pend && !(cur.size() == DW-1 && slot && !rb);
        chk(ready_a == exp_ra, "ready_a", ready_a, exp_ra);
        chk(ready_a1 == exp_ra, "ready_a1", ready_a1, exp_ra);
        xf = va && exp_ra;
        fr = !slot || rb;
        if (slot && rb) slot = 0;
        if (xf) cur.push_back(da);
        if (cur.size() == DW) begin
            emit();
        end else if (FL && (fl || pend) && cur.size() > 0) begin
            if (fr) begin
                emit();
                pend = 0;
            end else begin
                pend = 1;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        #1;
        rst = 1; valid_a = 0; flush = 0; ready_b = 0;
        #1;
        chk(ready_a == 0, "rst_ready_a", ready_a, 0);
        chk(valid_b0 == 0 && valid_b1 == 0, "rst_valid_b", valid_b0, 0);
        chk(data0 == 0 && data1 == 0, "rst_data_b", data0, 0);
        if (FL) chk(cnt0 == 0, "rst_cnt_b", cnt0, 0);
        cur.delete(); q0.delete(); q1.delete(); qc.delete();
        slot = 0; pend = 0;
        @(negedge clk);
        #1;
        rst = 0;
    endtask

    // Monitor: sample the handshake in the window before the next rising edge.
    initial begin
        bit hold = 0;
        logic [DW-1:0] hd0, hd1;
        logic [DW-1:0] e0, e1;
        int ec;
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                hold = 0;
            end else begin
                chk(valid_b0 == valid_b1, "valid_pair", valid_b1, valid_b0);
                if (hold)
                    chk(valid_b0 && data0 == hd0 && data1 == hd1, "hold",
                        data0, hd0);
                if (valid_b0 && ready_b) begin
                    if (q0.size() == 0) begin
                        chk(0, "unexpected_word", data0, 0);
                    end else begin
                        e0 = q0.pop_front();
                        e1 = q1.pop_front();
                        ec = qc.pop_front();
                        chk(data0 == e0, "word_lsb", data0, e0);
                        chk(data1 == e1, "word_msb", data1, e1);
                        if (FL) begin
                            chk(cnt0 == CW'(ec), "cnt_b_lsb", cnt0, ec);
                            chk(cnt1 == CW'(ec), "cnt_b_msb", cnt1, ec);
                        end
                    end
                end
                hold = valid_b0 && !ready_b;
                hd0 = data0;
                hd1 = data1;
            end
        end
    end

    initial begin
        bit pat[6] = '{1, 0, 1, 1, 0, 0};
        do_reset();

        // Single word, consumer always ready.
        foreach (pat[i]) cycle(1, pat[i], 1, 0);
        cycle(0, 0, 1, 0);
        chk(valid_b0 == 1, "w1_valid", valid_b0, 1);
        chk(data0 == 6'b001101, "w1_lsb", data0, 6'b001101);
        chk(data1 == 6'b101100, "w1_msb", data1, 6'b101100);
        cycle(0, 0, 1, 0);
        chk(valid_b0 == 0, "w1_pulse", valid_b0, 0);

        // Blocked consumer: second word stalls on its last bit.
        for (int i = 0; i < 13; i++) cycle(1, 1'($urandom), 0, 0);
        chk(ready_a == 0, "stall_ready_a", ready_a, 0);
        cycle(1, 1, 1, 0);
        cycle(0, 0, 1, 0);
        chk(valid_b0 == 1, "w2_loaded", valid_b0, 1);
        cycle(0, 0, 1, 0);

        // Reset mid-word discards partial bits.
        for (int i = 0; i < 3; i++) cycle(1, 0, 1, 0);
        do_reset();
        for (int i = 0; i < 6; i++) cycle(1, 1, 1, 0);
        cycle(0, 0, 1, 0);
        chk(data0 == 6'b111111, "post_rst", data0, 6'b111111);
        cycle(0, 0, 1, 0);

`ifdef S2P_FLUSH_EN
        cycle(1, 1, 1, 0);
        cycle(1, 1, 1, 0);
        cycle(1, 0, 1, 0);
        cycle(0, 0, 1, 1);
        cycle(0, 0, 1, 0);
        chk(data0 == 6'b000011, "flush_data", data0, 6'b000011);
        chk(cnt0 == 3, "flush_cnt", cnt0, 3);
        for (int i = 0; i < 6; i++) cycle(1, 1'($urandom), 1, 0);
        cycle(0, 0, 1, 0);
        chk(cnt0 == CW'(DW), "full_cnt", cnt0, DW);
        cycle(0, 0, 1, 0);
        // Flush while the slot is held: pending until the consumer drains.
        for (int i = 0; i < 8; i++) cycle(1, 1'($urandom), 0, 0);
        cycle(0, 0, 0, 1);
        cycle(1, 1, 0, 0);
        chk(ready_a == 0, "pend_ready_a", ready_a, 0);
        cycle(1, 1, 1, 0);
        cycle(0, 0, 1, 0);
        chk(cnt0 == 2, "pend_cnt", cnt0, 2);
        cycle(0, 0, 1, 0);
`endif

        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 599) == 0) do_reset();
            cycle($urandom_range(0, 3) != 0, 1'($urandom),
                  $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
        end

        for (int i = 0; i < DW + 4; i++) cycle(0, 0, 1, 0);
        @(negedge clk);
        #4;
        chk(q0.size() == 0, "drain", q0.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
